// File: rtl/bp_pkg.sv
// Shared types and helpers for the tournament branch predictor: 2-bit
// saturating counters, chooser encodings and the counter update rule.
package bp_pkg;

  typedef logic [1:0] ctr2_t;

  localparam ctr2_t CTR_RESET = 2'b01;
  localparam ctr2_t CTR_MIN   = 2'b00;
  localparam ctr2_t CTR_MAX   = 2'b11;

  localparam ctr2_t CPHT_STRONG_LOCAL  = 2'b00;
  localparam ctr2_t CPHT_WEAK_LOCAL    = 2'b01;
  localparam ctr2_t CPHT_WEAK_GLOBAL   = 2'b10;
  localparam ctr2_t CPHT_STRONG_GLOBAL = 2'b11;

  function automatic ctr2_t satUpdate(input ctr2_t ctr, input logic up);
    ctr2_t res;
    if (up) begin
      res = (ctr == CTR_MAX) ? ctr : ctr + 2'b01;
    end else begin
      res = (ctr == CTR_MIN) ? ctr : ctr - 2'b01;
    end
    return res;
  endfunction

endpackage

// File: rtl/pht_table.sv
// 2^N-entry table of 2-bit saturating counters with one combinational read
// port and one synchronous update port (up = count toward 11).
module pht_table
  import bp_pkg::*;
#(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] rdIdx,
  output ctr2_t        rdCtr,
  input  logic         wrEn,
  input  logic [N-1:0] wrIdx,
  input  logic         wrUp
);

  ctr2_t ctrTable_r [1 << N];

  // Counter storage: reset to weak state, saturating update on write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < (1 << N); i++) begin
        ctrTable_r[i] <= CTR_RESET;
      end
    end else if (wrEn) begin
      ctrTable_r[wrIdx] <= satUpdate(ctrTable_r[wrIdx], wrUp);
    end
  end

  // Reads see the stored value, so a same-cycle update is visible next cycle.
  assign rdCtr = ctrTable_r[rdIdx];

endmodule

// File: rtl/tournament_predictor.sv
// Tournament branch predictor: local (BHT-indexed) and gshare-style global
// PHTs with a chooser table. Optional counters under TOURNAMENT_STATS_EN.
module tournament_predictor
  import bp_pkg::*;
#(
  parameter int PHT_INDEX_BITS     = 10,
  parameter int LOCAL_PC_HASH_BITS = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   pcF,
  input  logic                          branchE,
  input  logic                          actually_takenE,
  input  logic                          local_predict_resultE,
  input  logic                          global_predict_resultE,
  input  logic [PHT_INDEX_BITS-1:0]     local_PHT_indexE,
  input  logic [PHT_INDEX_BITS-1:0]     global_PHT_indexE,
  input  logic [LOCAL_PC_HASH_BITS-1:0] pc_hashingE,
  output logic                          local_predict_takeF,
  output logic                          global_predict_takeF,
  output logic                          predict_takeF,
  output logic [PHT_INDEX_BITS-1:0]     local_PHT_indexF,
  output logic [PHT_INDEX_BITS-1:0]     global_PHT_indexF,
  output logic [LOCAL_PC_HASH_BITS-1:0] pc_hashingF
`ifdef TOURNAMENT_STATS_EN
  ,
  output logic [31:0]                   branch_cnt,
  output logic [31:0]                   local_miss_cnt,
  output logic [31:0]                   global_miss_cnt
`endif
);

  logic [PHT_INDEX_BITS-1:0] bht_r [1 << LOCAL_PC_HASH_BITS];
  logic [PHT_INDEX_BITS-1:0] ghr_r;
  ctr2_t                     localCtr_s;
  ctr2_t                     globalCtr_s;
  ctr2_t                     choiceCtr_s;
  logic                      cphtWrEn_s;
  logic                      unusedBits_s;

  // Fetch-side lookup indices.
  assign pc_hashingF       = pcF[LOCAL_PC_HASH_BITS+1:2];
  assign local_PHT_indexF  = bht_r[pc_hashingF];
  assign global_PHT_indexF = ghr_r ^ pcF[PHT_INDEX_BITS+1:2];

  assign local_predict_takeF  = localCtr_s[1];
  assign global_predict_takeF = globalCtr_s[1];
  assign predict_takeF        = choiceCtr_s[1] ? global_predict_takeF : local_predict_takeF;

  // Chooser only trains when exactly one predictor was right.
  assign cphtWrEn_s = branchE & (local_predict_resultE ^ global_predict_resultE);

  assign unusedBits_s = ^{pcF[31:PHT_INDEX_BITS+2], pcF[1:0],
                          localCtr_s[0], globalCtr_s[0], choiceCtr_s[0]};

  // History registers: per-PC-hash local history and global history.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_r <= {PHT_INDEX_BITS{1'b0}};
      for (int i = 0; i < (1 << LOCAL_PC_HASH_BITS); i++) begin
        bht_r[i] <= {PHT_INDEX_BITS{1'b0}};
      end
    end else if (branchE) begin
      ghr_r              <= {ghr_r[PHT_INDEX_BITS-2:0], actually_takenE};
      bht_r[pc_hashingE] <= {bht_r[pc_hashingE][PHT_INDEX_BITS-2:0], actually_takenE};
    end
  end

  pht_table #(.N(PHT_INDEX_BITS)) uLocalPht (
    .clk   (clk),
    .rst   (rst),
    .rdIdx (local_PHT_indexF),
    .rdCtr (localCtr_s),
    .wrEn  (branchE),
    .wrIdx (local_PHT_indexE),
    .wrUp  (actually_takenE)
  );

  pht_table #(.N(PHT_INDEX_BITS)) uGlobalPht (
    .clk   (clk),
    .rst   (rst),
    .rdIdx (global_PHT_indexF),
    .rdCtr (globalCtr_s),
    .wrEn  (branchE),
    .wrIdx (global_PHT_indexE),
    .wrUp  (actually_takenE)
  );

  pht_table #(.N(PHT_INDEX_BITS)) uChoicePht (
    .clk   (clk),
    .rst   (rst),
    .rdIdx (global_PHT_indexF),
    .rdCtr (choiceCtr_s),
    .wrEn  (cphtWrEn_s),
    .wrIdx (global_PHT_indexE),
    .wrUp  (global_predict_resultE)
  );

`ifdef TOURNAMENT_STATS_EN
  // Wrapping event counters for resolved branches and per-predictor misses.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt      <= 32'd0;
      local_miss_cnt  <= 32'd0;
      global_miss_cnt <= 32'd0;
    end else if (branchE) begin
      branch_cnt <= branch_cnt + 32'd1;
      if (!local_predict_resultE) begin
        local_miss_cnt <= local_miss_cnt + 32'd1;
      end
      if (!global_predict_resultE) begin
        global_miss_cnt <= global_miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tournament_predictor.sv
// Directed self-checking bench for tournament_predictor (default parameters);
// the statistics counters are exercised when TOURNAMENT_STATS_EN is defined.
module tb_tournament_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] pcF;
  logic        branchE;
  logic        actually_takenE;
  logic        local_predict_resultE;
  logic        global_predict_resultE;
  logic [9:0]  local_PHT_indexE;
  logic [9:0]  global_PHT_indexE;
  logic [2:0]  pc_hashingE;
  logic        local_predict_takeF;
  logic        global_predict_takeF;
  logic        predict_takeF;
  logic [9:0]  local_PHT_indexF;
  logic [9:0]  global_PHT_indexF;
  logic [2:0]  pc_hashingF;
`ifdef TOURNAMENT_STATS_EN
  logic [31:0] branch_cnt;
  logic [31:0] local_miss_cnt;
  logic [31:0] global_miss_cnt;
`endif

  int errCnt = 0;
  int chkCnt = 0;

  tournament_predictor dut (
    .clk                    (clk),
    .rst                    (rst),
    .pcF                    (pcF),
    .branchE                (branchE),
    .actually_takenE        (actually_takenE),
    .local_predict_resultE  (local_predict_resultE),
    .global_predict_resultE (global_predict_resultE),
    .local_PHT_indexE       (local_PHT_indexE),
    .global_PHT_indexE      (global_PHT_indexE),
    .pc_hashingE            (pc_hashingE),
    .local_predict_takeF    (local_predict_takeF),
    .global_predict_takeF   (global_predict_takeF),
    .predict_takeF          (predict_takeF),
    .local_PHT_indexF       (local_PHT_indexF),
    .global_PHT_indexF      (global_PHT_indexF),
    .pc_hashingF            (pc_hashingF)
`ifdef TOURNAMENT_STATS_EN
    ,
    .branch_cnt             (branch_cnt),
    .local_miss_cnt         (local_miss_cnt),
    .global_miss_cnt        (global_miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [31:0] pc);
    pcF = pc;
    #1;
  endtask

  task automatic doReset(input logic withBranch);
    rst     = 1'b1;
    branchE = withBranch;
    tick();
    rst     = 1'b0;
    branchE = 1'b0;
  endtask

  task automatic upd(input logic tk, input logic lr, input logic gr,
                     input logic [9:0] li, input logic [9:0] gi, input logic [2:0] h);
    branchE                = 1'b1;
    actually_takenE        = tk;
    local_predict_resultE  = lr;
    global_predict_resultE = gr;
    local_PHT_indexE       = li;
    global_PHT_indexE      = gi;
    pc_hashingE            = h;
    tick();
    branchE = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    lookup(32'h0);
    checkEq({tag, "_hash"}, {29'd0, pc_hashingF}, 32'd0);
    checkEq({tag, "_lidx"}, {22'd0, local_PHT_indexF}, 32'd0);
    checkEq({tag, "_gidx"}, {22'd0, global_PHT_indexF}, 32'd0);
    checkEq({tag, "_ltake"}, {31'd0, local_predict_takeF}, 32'd0);
    checkEq({tag, "_gtake"}, {31'd0, global_predict_takeF}, 32'd0);
    checkEq({tag, "_ptake"}, {31'd0, predict_takeF}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; pcF = 32'h0; branchE = 1'b0; actually_takenE = 1'b0;
    local_predict_resultE = 1'b0; global_predict_resultE = 1'b0;
    local_PHT_indexE = 10'd0; global_PHT_indexE = 10'd0; pc_hashingE = 3'd0;
    tick();
    doReset(1'b0);
    checkAllZero("rst");

    // Taken update at index 0; same-cycle lookup still sees weak-not-taken.
    pcF = 32'h0; branchE = 1'b1; actually_takenE = 1'b1;
    local_predict_resultE = 1'b1; global_predict_resultE = 1'b1;
    local_PHT_indexE = 10'd0; global_PHT_indexE = 10'd0; pc_hashingE = 3'd0;
    #1;
    checkEq("same_cyc_ltake", {31'd0, local_predict_takeF}, 32'd0);
    checkEq("same_cyc_gtake", {31'd0, global_predict_takeF}, 32'd0);
    tick();
    branchE = 1'b0;
    lookup(32'h4);
    checkEq("u1_hash", {29'd0, pc_hashingF}, 32'd1);
    checkEq("u1_lidx", {22'd0, local_PHT_indexF}, 32'd0);
    checkEq("u1_gidx", {22'd0, global_PHT_indexF}, 32'd0);
    checkEq("u1_ltake", {31'd0, local_predict_takeF}, 32'd1);
    checkEq("u1_gtake", {31'd0, global_predict_takeF}, 32'd1);
    checkEq("u1_ptake", {31'd0, predict_takeF}, 32'd1);
    lookup(32'h0);
    checkEq("u1_bht0", {22'd0, local_PHT_indexF}, 32'd1);
    checkEq("u1_ghr", {22'd0, global_PHT_indexF}, 32'd1);

    // Idle cycles with junk E inputs must not touch any state.
    actually_takenE = 1'b0; local_predict_resultE = 1'b0; global_predict_resultE = 1'b0;
    local_PHT_indexE = 10'd0; global_PHT_indexE = 10'd0; pc_hashingE = 3'd0;
    for (int i = 0; i < 3; i++) tick();
    lookup(32'h0);
    checkEq("idle_bht0", {22'd0, local_PHT_indexF}, 32'd1);
    checkEq("idle_ghr", {22'd0, global_PHT_indexF}, 32'd1);
    lookup(32'h4);
    checkEq("idle_ltake", {31'd0, local_predict_takeF}, 32'd1);

    // Local counter 3 saturation; BHT[4] is trained to 3 to read it back.
    upd(1'b1, 1'b1, 1'b1, 10'd3, 10'd100, 3'd4);
    upd(1'b1, 1'b1, 1'b1, 10'd3, 10'd100, 3'd4);
    upd(1'b1, 1'b1, 1'b1, 10'd3, 10'd100, 3'd5);
    upd(1'b1, 1'b1, 1'b1, 10'd3, 10'd100, 3'd5);
    lookup(32'h10);
    checkEq("sat_lidx", {22'd0, local_PHT_indexF}, 32'd3);
    checkEq("sat_11", {31'd0, local_predict_takeF}, 32'd1);
    upd(1'b0, 1'b1, 1'b1, 10'd3, 10'd100, 3'd6);
    lookup(32'h10);
    checkEq("sat_10", {31'd0, local_predict_takeF}, 32'd1);
    upd(1'b0, 1'b1, 1'b1, 10'd3, 10'd100, 3'd6);
    lookup(32'h10);
    checkEq("sat_01", {31'd0, local_predict_takeF}, 32'd0);
    upd(1'b0, 1'b1, 1'b1, 10'd3, 10'd100, 3'd6);
    upd(1'b0, 1'b1, 1'b1, 10'd3, 10'd100, 3'd6);
    upd(1'b1, 1'b1, 1'b1, 10'd3, 10'd100, 3'd6);
    lookup(32'h10);
    checkEq("sat_00_stay", {31'd0, local_predict_takeF}, 32'd0);
    upd(1'b1, 1'b1, 1'b1, 10'd3, 10'd100, 3'd6);
    lookup(32'h10);
    checkEq("sat_back_10", {31'd0, local_predict_takeF}, 32'd1);

    // Mid-operation reset overriding a simultaneous update.
    actually_takenE = 1'b1; local_PHT_indexE = 10'd0; global_PHT_indexE = 10'd0;
    pc_hashingE = 3'd0;
    doReset(1'b1);
    checkAllZero("midrst");

    // Chooser: equal results leave CPHT[0] at weak-local.
    upd(1'b1, 1'b1, 1'b1, 10'd9, 10'd0, 3'd1);
    lookup(32'h4);
    checkEq("cp_eq_gidx", {22'd0, global_PHT_indexF}, 32'd0);
    checkEq("cp_eq_lidx", {22'd0, local_PHT_indexF}, 32'd1);
    checkEq("cp_eq_gtake", {31'd0, global_predict_takeF}, 32'd1);
    checkEq("cp_eq_ptake", {31'd0, predict_takeF}, 32'd0);
    // Two global-only-correct updates push CPHT[0] to strong-global.
    upd(1'b1, 1'b0, 1'b1, 10'd9, 10'd0, 3'd1);
    upd(1'b1, 1'b0, 1'b1, 10'd9, 10'd0, 3'd1);
    lookup(32'h1C);
    checkEq("cp_g_gidx", {22'd0, global_PHT_indexF}, 32'd0);
    checkEq("cp_g_ltake", {31'd0, local_predict_takeF}, 32'd0);
    checkEq("cp_g_ptake", {31'd0, predict_takeF}, 32'd1);
    // One local-only-correct update: 11 -> 10, still global.
    upd(1'b1, 1'b1, 1'b0, 10'd9, 10'd0, 3'd1);
    lookup(32'h3C);
    checkEq("cp_dec_gidx", {22'd0, global_PHT_indexF}, 32'd0);
    checkEq("cp_dec_ptake", {31'd0, predict_takeF}, 32'd1);
    // Second one: 10 -> 01, back to local.
    upd(1'b1, 1'b1, 1'b0, 10'd9, 10'd0, 3'd1);
    lookup(32'h7C);
    checkEq("cp_dec2_gidx", {22'd0, global_PHT_indexF}, 32'd0);
    checkEq("cp_dec2_ptake", {31'd0, predict_takeF}, 32'd0);

`ifdef TOURNAMENT_STATS_EN
    doReset(1'b0);
    checkEq("st_rst_br", branch_cnt, 32'd0);
    upd(1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 3'd0);
    upd(1'b0, 1'b0, 1'b1, 10'd1, 10'd1, 3'd1);
    upd(1'b1, 1'b1, 1'b1, 10'd2, 10'd2, 3'd2);
    tick();
    checkEq("st_branch", branch_cnt, 32'd3);
    checkEq("st_lmiss", local_miss_cnt, 32'd1);
    checkEq("st_gmiss", global_miss_cnt, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule

// File: doc/tournament_predictor.md
TOURNAMENT_PREDICTOR -- requirements
Module: tournament_predictor

Interface
REQ-001 SHALL have parameter PHT_INDEX_BITS, default 10, giving the PHT index width and the history register width.
REQ-002 SHALL have parameter LOCAL_PC_HASH_BITS, default 3, giving the BHT index width.
REQ-003 SHALL have port clk  in  1  the single clock, with all state on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port pcF  in  32  fetch-stage PC.
REQ-006 SHALL have port branchE  in  1  a branch is resolving in EX this cycle.
REQ-007 SHALL have port actually_takenE  in  1  resolved branch direction.
REQ-008 SHALL have port local_predict_resultE  in  1  the local prediction was correct.
REQ-009 SHALL have port global_predict_resultE  in  1  the global prediction was correct.
REQ-010 SHALL have port local_PHT_indexE  in  PHT_INDEX_BITS  local PHT index echoed back from fetch.
REQ-011 SHALL have port global_PHT_indexE  in  PHT_INDEX_BITS  global PHT index echoed back from fetch.
REQ-012 SHALL have port pc_hashingE  in  LOCAL_PC_HASH_BITS  BHT index echoed back from fetch.
REQ-013 SHALL have ports local_predict_takeF, global_predict_takeF, predict_takeF  out  1 each  local, global and selected predictions.
REQ-014 SHALL have ports local_PHT_indexF, global_PHT_indexF  out  PHT_INDEX_BITS  lookup indices.
REQ-015 SHALL have port pc_hashingF  out  LOCAL_PC_HASH_BITS  BHT index used for this lookup.

Function
REQ-016 SHALL hold BHT[2^LOCAL_PC_HASH_BITS] x PHT_INDEX_BITS, GHR (PHT_INDEX_BITS), and local PHT, global PHT and choice table CPHT, each 2^PHT_INDEX_BITS x 2-bit saturating counters.
REQ-017 SHALL derive, combinationally from pcF in the same cycle: pc_hashingF = pcF[LOCAL_PC_HASH_BITS+1:2]; local_PHT_indexF = BHT[pc_hashingF]; global_PHT_indexF = GHR XOR pcF[PHT_INDEX_BITS+1:2].
REQ-018 SHALL drive each take output as the MSB of its counter; predict_takeF = global_predict_takeF when CPHT[global_PHT_indexF][1]=1, else local_predict_takeF.
REQ-019 SHALL perform no state change when branchE=0.
REQ-020 SHALL, on a clock edge with branchE=1, update localPHT[local_PHT_indexE] and globalPHT[global_PHT_indexE] toward actually_takenE, saturating (00 stays 00 on not-taken; 11 stays 11 on taken).
REQ-021 SHALL, on the same edge, set BHT[pc_hashingE] to {old[PHT_INDEX_BITS-2:0], actually_takenE} and GHR to {GHR[PHT_INDEX_BITS-2:0], actually_takenE}.
REQ-022 SHALL leave CPHT[global_PHT_indexE] unchanged when local and global results are equal; otherwise increment it (saturating) if the global result is correct and decrement it if the local result is correct.
REQ-023 CPHT encoding SHALL be 00 strong-local, 01 weak-local, 10 weak-global, 11 strong-global.
REQ-024 Same-cycle lookup of an entry being updated SHALL return the pre-update value; the new value SHALL be visible from the next cycle.
REQ-025 Update latency SHALL be one edge; lookup latency SHALL be zero (combinational).

Reset
REQ-026 On rst=1, GHR and all BHT entries SHALL be 0, all PHT counters 01 and all CPHT counters 01; rst SHALL override any same-cycle update.
REQ-027 Mid-operation reset SHALL discard all training; with pcF=0 after reset, every output SHALL be 0.

Configuration
REQ-028 When macro TOURNAMENT_STATS_EN is defined, the block SHALL add outputs branch_cnt, local_miss_cnt and global_miss_cnt (32 bits each, reset 0, wrapping), incremented on branchE=1 edges, the miss counters only when their respective result input is 0.
REQ-029 When TOURNAMENT_STATS_EN is undefined, those ports and counters SHALL be absent.

Structure
REQ-030 Package bp_pkg SHALL hold the 2-bit counter typedef, the CPHT encodings, counter reset constant 2'b01 and a saturating-update function.
REQ-031 Sub-module pht_table (2^N x 2-bit, one combinational read port, one synchronous update port, parameterised N) SHALL be instantiated three times, for local PHT, global PHT and CPHT.

Verification
REQ-032 Reset then pcF=0x0 -> all six F outputs are 0.
REQ-033 One update (branchE=1, taken=1, all E indices 0), then pcF=0x4 -> pc_hashingF=1, local_PHT_indexF=0, global_PHT_indexF=0, all three takes are 1, GHR=1, BHT[0]=1.
REQ-034 Four taken updates at local index 3 then one not-taken -> counter 11 then 10, still predicts taken; a not-taken update on a 00 counter stays 00.
REQ-035 Two updates with local_result=0, global_result=1 at global index 0 -> CPHT[0]=11 and predict_takeF follows global_predict_takeF; both results 1 -> CPHT unchanged.
REQ-036 An update and a lookup of the same index in the same cycle -> the lookup shows the old counter, and the new value appears next cycle.
REQ-037 With TOURNAMENT_STATS_EN, three branches, one with local_result=0, plus one cycle with branchE=0 -> branch_cnt=3, local_miss_cnt=1, global_miss_cnt=0.
